weight_fifo: RTL and testbench

Parameterised bank of independent per-lane shift-register FIFOs that buffers systolic-array weights between the weight memory (mem_arr) and the array. Each lane is a fixed-depth chain of data registers that advances only when that lane's enable bit is high. The per-lane enables come from the FIFO control block, which drives them staggered or all-at-once. Word N of a lane appears at that lane's output after FIFO_DEPTH enabled shifts.

---
 rtl/weight_fifo.sv | 127 ++++++++++++
 tb/tb_weight_fifo.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_fifo.sv
// -----------------------------------------------------------------------------
// weight_fifo
//
// A bank of independent per-lane shift-register FIFOs. They buffer systolic
// array weights between the weight memory and the array. Each lane is a chain
// of FIFO_DEPTH data registers, and the chain advances only when that lane's
// enable bit is high. There are no full or empty flags. The external
// controller counts shifts.
//
// Parameters:
//   FIFO_INPUTS  number of independent lanes
//   FIFO_DEPTH   register stages per lane (>= 1)
//   DATA_WIDTH   bits per weight word
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low; clears every stage
//   en         per-lane shift enable, bit i controls lane i
//   weightIn   lane i word = weightIn[i*DATA_WIDTH +: DATA_WIDTH]
//   weightOut  last stage of each lane, packed the same way (registered)
//   valid_in   per-lane tag shifted alongside the data   (WEIGHT_FIFO_VALID_EN)
//   valid_out  tag of the last stage of each lane        (WEIGHT_FIFO_VALID_EN)
//
// Build option:
//   WEIGHT_FIFO_VALID_EN  defining this macro adds a 1-bit tag chain per lane.
//                         The consumer uses the tags to ignore zero-fill and
//                         padding. The data path is the same in both builds.
// -----------------------------------------------------------------------------
module weight_fifo #(
    parameter int FIFO_INPUTS = 16,
    parameter int FIFO_DEPTH  = 16,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [FIFO_INPUTS-1:0]            en,
    input  logic [FIFO_INPUTS*DATA_WIDTH-1:0] weightIn,
`ifdef WEIGHT_FIFO_VALID_EN
    input  logic [FIFO_INPUTS-1:0]            valid_in,
    output logic [FIFO_INPUTS-1:0]            valid_out,
`endif
    output logic [FIFO_INPUTS*DATA_WIDTH-1:0] weightOut
);

    // Stage 0 is the write end and stage FIFO_DEPTH-1 is the output end.
    logic [DATA_WIDTH-1:0] stage_q [FIFO_INPUTS][FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] stage_d [FIFO_INPUTS][FIFO_DEPTH];

    always_comb begin
        // NOTE: take a full default from the current state before any
        // conditional update, so no path leaves stage_d unassigned (no latch).
        stage_d = stage_q;
        for (int i = 0; i < FIFO_INPUTS; i++) begin
            if (en[i]) begin
                stage_d[i][0] = weightIn[i*DATA_WIDTH +: DATA_WIDTH];
                // When FIFO_DEPTH is 1 this loop is empty. The lane is then a
                // single enabled register.
                for (int k = 1; k < FIFO_DEPTH; k++) begin
                    stage_d[i][k] = stage_q[i][k-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: every stage is reset, not only the output stage. A reset
            // during a fill must discard partial contents, and the zero-fill
            // behind the first real word is part of the observable stream.
            for (int i = 0; i < FIFO_INPUTS; i++) begin
                for (int k = 0; k < FIFO_DEPTH; k++) begin
                    stage_q[i][k] <= '0;
                end
            end
        end else begin
            // NOTE: use non-blocking assignments so that every stage samples
            // its neighbour's pre-edge value.
            stage_q <= stage_d;
        end
    end

    // The output comes straight from the last flop of each lane. There is no
    // combinational path from weightIn or en.
    always_comb begin
        weightOut = '0;
        for (int i = 0; i < FIFO_INPUTS; i++) begin
            weightOut[i*DATA_WIDTH +: DATA_WIDTH] = stage_q[i][FIFO_DEPTH-1];
        end
    end

`ifdef WEIGHT_FIFO_VALID_EN
    // The tag chain is a parallel 1-bit shadow of the data chain. It shifts
    // under the same enable, so a tag always travels with its data word.
    logic [FIFO_DEPTH-1:0] tag_q [FIFO_INPUTS];
    logic [FIFO_DEPTH-1:0] tag_d [FIFO_INPUTS];

    always_comb begin
        tag_d = tag_q;
        for (int i = 0; i < FIFO_INPUTS; i++) begin
            if (en[i]) begin
                tag_d[i][0] = valid_in[i];
                for (int k = 1; k < FIFO_DEPTH; k++) begin
                    tag_d[i][k] = tag_q[i][k-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_INPUTS; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q <= tag_d;
        end
    end

    always_comb begin
        valid_out = '0;
        for (int i = 0; i < FIFO_INPUTS; i++) begin
            valid_out[i] = tag_q[i][FIFO_DEPTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_weight_fifo.sv
// -----------------------------------------------------------------------------
// tb_weight_fifo
//
// Self-checking bench for weight_fifo. The reference model keeps one queue of
// FIFO_DEPTH words per lane. Each enabled edge pushes the new word at the front
// and drops the oldest word. The expected output is the oldest word still held.
// Directed scenarios cover reset, full fill, ordered drain, staggered enables,
// hold and reset during a fill. They are followed by a randomized soak.
// Defining WEIGHT_FIFO_VALID_EN also checks the tag chain.
// -----------------------------------------------------------------------------
module tb_weight_fifo;

    localparam int LANES = 16;
    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int VW    = LANES * DW;

    logic             clk = 1'b0;
    logic             reset;
    logic [LANES-1:0] en;
    logic [VW-1:0]    weight_in;
    logic [VW-1:0]    weight_out;
`ifdef WEIGHT_FIFO_VALID_EN
    logic [LANES-1:0] valid_in;
    logic [LANES-1:0] valid_out;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the front of each queue is the write end.
    logic [DW-1:0] mq [LANES][$];
    bit            tq [LANES][$];

    weight_fifo #(
        .FIFO_INPUTS(LANES),
        .FIFO_DEPTH (DEPTH),
        .DATA_WIDTH (DW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .weightIn (weight_in),
`ifdef WEIGHT_FIFO_VALID_EN
        .valid_in (valid_in),
        .valid_out(valid_out),
`endif
        .weightOut(weight_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < LANES; i++) begin
            mq[i].delete();
            tq[i].delete();
            for (int k = 0; k < DEPTH; k++) begin
                mq[i].push_back('0);
                tq[i].push_back(1'b0);
            end
        end
    endtask

    task automatic model_shift();
        for (int i = 0; i < LANES; i++) begin
            if (en[i]) begin
                mq[i].push_front(weight_in[i*DW +: DW]);
                void'(mq[i].pop_back());
`ifdef WEIGHT_FIFO_VALID_EN
                tq[i].push_front(valid_in[i]);
`else
                tq[i].push_front(1'b0);
`endif
                void'(tq[i].pop_back());
            end
        end
    endtask

    function automatic logic [VW-1:0] model_out();
        logic [VW-1:0] v = '0;
        for (int i = 0; i < LANES; i++) v[i*DW +: DW] = mq[i][$];
        return v;
    endfunction

    function automatic logic [LANES-1:0] model_valid();
        logic [LANES-1:0] v = '0;
        for (int i = 0; i < LANES; i++) v[i] = tq[i][$];
        return v;
    endfunction

    // Compare the DUT against the model, including the tags when they exist.
    task automatic compare(input string tag);
        check(tag, weight_out, model_out());
`ifdef WEIGHT_FIFO_VALID_EN
        check({tag, "_valid"}, {{(VW-LANES){1'b0}}, valid_out}, {{(VW-LANES){1'b0}}, model_valid()});
`endif
    endtask

    // Run one clock edge. Inputs are sampled at the edge, then checked 1 ns later.
    task automatic tick(input string tag);
        @(posedge clk);
        if (reset) model_shift();
        #1;
        compare(tag);
    endtask

    // Assert reset between edges and check that the clear is immediate.
    task automatic async_reset(input int hold_cycles);
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        check("async_reset_immediate", weight_out, '0);
`ifdef WEIGHT_FIFO_VALID_EN
        check("async_reset_valid", {{(VW-LANES){1'b0}}, valid_out}, '0);
`endif
        for (int c = 0; c < hold_cycles; c++) tick("reset_hold");
        reset = 1'b1;
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int w = 0; w < VW / 32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        logic [VW-1:0] fill_vec;
        logic [DW-1:0] held;
        int            cnt [LANES];

        model_clear();
        reset     = 1'b0;
        en        = '1;
        weight_in = rand_vec();
`ifdef WEIGHT_FIFO_VALID_EN
        valid_in  = '1;
`endif
        #1;
        check("reset_at_t0", weight_out, '0);

        // Reset held low with active enables and random data: the output stays 0.
        for (int c = 0; c < 5; c++) begin
            tick("reset_active");
            weight_in = rand_vec();
        end
        reset = 1'b1;

        // Full fill: lane i is fed 16-i. Visible only after the 16th edge.
        for (int i = 0; i < LANES; i++) fill_vec[i*DW +: DW] = DW'(LANES - i);
        weight_in = fill_vec;
        en        = '1;
`ifdef WEIGHT_FIFO_VALID_EN
        valid_in  = '0;
`endif
        for (int e = 1; e <= DEPTH; e++) begin
            tick("full_fill");
            if (e == DEPTH - 1) check("full_fill_edge15_zero", weight_out, '0);
            if (e == DEPTH)     check("full_fill_edge16", weight_out, fill_vec);
        end

        // Ordered drain on lane 0 only: write 1..16, then 16 zeros.
        en = 16'h0001;
        for (int e = 1; e <= 2 * DEPTH; e++) begin
            weight_in = (e <= DEPTH) ? VW'(e) : '0;
            tick("drain");
            if (e >= DEPTH && e < 2 * DEPTH)
                check("drain_lane0", VW'(weight_out[DW-1:0]), VW'(e - DEPTH + 1));
            if (e == 2 * DEPTH)
                check("drain_lane0_tail", VW'(weight_out[DW-1:0]), '0);
        end

        // Staggered enables: lane i starts shifting at cycle i, all lanes fed A5.
        async_reset(1);
        for (int i = 0; i < LANES; i++) begin
            weight_in[i*DW +: DW] = 8'hA5;
            cnt[i] = 0;
        end
        for (int c = 0; c < 2 * DEPTH; c++) begin
            for (int i = 0; i < LANES; i++) en[i] = (c >= i);
            tick("stagger");
            for (int i = 0; i < LANES; i++) begin
                if (en[i]) begin
                    cnt[i]++;
                    if (cnt[i] == DEPTH - 1)
                        check($sformatf("stagger_lane%0d_pre", i), VW'(weight_out[i*DW +: DW]), '0);
                    if (cnt[i] == DEPTH)
                        check($sformatf("stagger_lane%0d_a5", i), VW'(weight_out[i*DW +: DW]), VW'(8'hA5));
                end
            end
        end

        // Hold: fill everything, then freeze lane 3 while the others shift.
        en = '1;
        for (int c = 0; c < DEPTH; c++) begin
            weight_in = rand_vec();
            tick("hold_fill");
        end
        held = mq[3][$];
        for (int c = 0; c < 10; c++) begin
            en        = LANES'($urandom) | 16'hFFF7;
            en[3]     = 1'b0;
            weight_in = rand_vec();
            tick("hold_others");
            check("hold_lane3", VW'(weight_out[3*DW +: DW]), VW'(held));
        end

        // Reset in the middle of a fill, then refill with tags set.
        en = '1;
`ifdef WEIGHT_FIFO_VALID_EN
        valid_in = '0;
`endif
        for (int c = 0; c < 8; c++) begin
            weight_in = rand_vec();
            tick("midfill");
        end
        async_reset(2);
`ifdef WEIGHT_FIFO_VALID_EN
        valid_in = '1;
`endif
        for (int e = 1; e <= DEPTH; e++) begin
            weight_in = rand_vec();
            tick("refill");
`ifdef WEIGHT_FIFO_VALID_EN
            if (e == DEPTH - 1) check("refill_valid_low", {{(VW-LANES){1'b0}}, valid_out}, '0);
            if (e == DEPTH)     check("refill_valid_high", {{(VW-LANES){1'b0}}, valid_out}, {{(VW-LANES){1'b0}}, {LANES{1'b1}}});
`endif
        end

        // Random soak with occasional asynchronous resets.
        for (int c = 0; c < 400; c++) begin
            en        = LANES'($urandom);
            weight_in = rand_vec();
`ifdef WEIGHT_FIFO_VALID_EN
            valid_in  = LANES'($urandom);
`endif
            if ($urandom_range(0, 60) == 0) async_reset($urandom_range(0, 2));
            else tick("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
